// File: rtl/apb_mem_completer_if.sv
// APB signal bundle between a requester and the memory completer.
interface apb_mem_completer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [2:0]            pprot;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_completer.sv
// Word-addressed APB3/APB4 memory completer with wait states, error responses
// and a requester-side protocol monitor.
module apb_mem_completer #(
  parameter int PROTOCOL    = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int SECURE_ONLY = 0
) (
  input  logic               pclk,
  input  logic               prst,
  apb_mem_completer_if.slave apb,
  output logic               proto_err,
  output logic [7:0]         viol_count
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_strb;
  logic [IDX_W-1:0]    r_idx;
  logic                r_err;
  logic [3:0]          r_cnt;
  logic                r_pready;
  logic [DATA_W-1:0]   r_prdata;
  logic                r_proto_err;
  logic [7:0]          r_viol_count;

  logic [ADDR_W-1:0]   w_index;
  logic                w_err;
  logic                w_setup;
  logic                w_complete;
  logic                w_abort;
  logic                w_viol;
  logic                w_unused;

  assign w_index  = apb.paddr >> LSB;
  assign w_err    = ({1'b0, w_index} >= DEPTH_EXT)
                  || (|(apb.paddr & LOW_MASK))
                  || ((SECURE_ONLY != 0) && (PROTOCOL == 4) && apb.pprot[1]);
  assign w_unused = ^{apb.pprot[2], apb.pprot[0]};

  always_ff @(posedge pclk) begin
    if (prst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Several simultaneous violations collapse into a single w_viol pulse.
  always_comb begin
    w_next     = r_state;
    w_setup    = 1'b0;
    w_complete = 1'b0;
    w_abort    = 1'b0;
    w_viol     = 1'b0;
    case (r_state)
      IDLE: begin
        if (apb.penable) begin
          w_viol = 1'b1;
        end else if (apb.psel) begin
          w_setup = 1'b1;
          w_next  = ACCESS;
          if ((PROTOCOL == 4) && !apb.pwrite && (|apb.pstrb)) w_viol = 1'b1;
        end
      end
      ACCESS: begin
        if (apb.psel && apb.penable) begin
          if (r_pready) begin
            w_complete = 1'b1;
            w_next     = IDLE;
          end
        end else begin
          w_abort = 1'b1;
          w_viol  = 1'b1;
          w_next  = IDLE;
        end
        if ((apb.paddr != r_addr) || (apb.pwrite != r_write) || (apb.pwdata != r_wdata))
          w_viol = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_cnt        <= 4'd0;
      r_pready     <= 1'b0;
      r_prdata     <= '0;
      r_proto_err  <= 1'b0;
      r_viol_count <= 8'd0;
    end else begin
      if (w_viol) begin
        r_proto_err <= 1'b1;
        if (r_viol_count != 8'hFF) r_viol_count <= r_viol_count + 8'd1;
      end
      if (w_setup) begin
        r_addr   <= apb.paddr;
        r_write  <= apb.pwrite;
        r_wdata  <= apb.pwdata;
        r_strb   <= (PROTOCOL == 3) ? '1 : apb.pstrb;
        r_idx    <= w_index[IDX_W-1:0];
        r_err    <= w_err;
        r_prdata <= w_err ? '0 : r_mem[w_index[IDX_W-1:0]];
        r_cnt    <= WAIT_INIT;
        r_pready <= (WAIT_INIT == 4'd0);
      end else if (w_complete || w_abort) begin
        r_pready <= 1'b0;
        r_err    <= 1'b0;
      end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt    <= r_cnt - 4'd1;
        r_pready <= (r_cnt == 4'd1);
      end
    end
  end

  // Memory has no reset; only an error-free completing write touches it.
  always_ff @(posedge pclk) begin
    if (!prst && w_complete && r_write && !r_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_strb[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_err & r_pready;
  assign proto_err   = r_proto_err;
  assign viol_count  = r_viol_count;
endmodule

// File: tb/tb_apb_mem_completer.sv
// Scoreboard bench: three completer configurations share one driven bus, and a
// negedge monitor checks every completion against queued expectations.
module tb_apb_mem_completer;
  logic        pclk = 1'b0;
  logic        prst;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int          tgt = 0;
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          startCycle;

  typedef struct {
    logic        isWrite;
    logic [31:0] data;
    logic        err;
    int          waits;
  } expect_t;
  expect_t expQ[$];

  logic       protoErrA, protoErrB, protoErrC;
  logic [7:0] violA, violB, violC;
  logic        curPready, curPslverr;
  logic [31:0] curPrdata;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cycleCount++;

  apb_mem_completer_if #(.ADDR_W(16), .DATA_W(32)) ifA ();
  apb_mem_completer_if #(.ADDR_W(16), .DATA_W(32)) ifB ();
  apb_mem_completer_if #(.ADDR_W(16), .DATA_W(32)) ifC ();

  // Only the targeted completer sees psel/penable; the others stay idle.
  assign ifA.psel = psel && (tgt == 0);
  assign ifA.penable = penable && (tgt == 0);
  assign ifA.pwrite = pwrite;
  assign ifA.paddr = paddr;
  assign ifA.pwdata = pwdata;
  assign ifA.pstrb = pstrb;
  assign ifA.pprot = pprot;
  assign ifB.psel = psel && (tgt == 1);
  assign ifB.penable = penable && (tgt == 1);
  assign ifB.pwrite = pwrite;
  assign ifB.paddr = paddr;
  assign ifB.pwdata = pwdata;
  assign ifB.pstrb = pstrb;
  assign ifB.pprot = pprot;
  assign ifC.psel = psel && (tgt == 2);
  assign ifC.penable = penable && (tgt == 2);
  assign ifC.pwrite = pwrite;
  assign ifC.paddr = paddr;
  assign ifC.pwdata = pwdata;
  assign ifC.pstrb = pstrb;
  assign ifC.pprot = pprot;

  assign curPready  = (tgt == 0) ? ifA.pready  : (tgt == 1) ? ifB.pready  : ifC.pready;
  assign curPslverr = (tgt == 0) ? ifA.pslverr : (tgt == 1) ? ifB.pslverr : ifC.pslverr;
  assign curPrdata  = (tgt == 0) ? ifA.prdata  : (tgt == 1) ? ifB.prdata  : ifC.prdata;

  apb_mem_completer #(.PROTOCOL(4), .ADDR_W(16), .DATA_W(32), .DEPTH(256),
                      .WAIT_STATES(0), .SECURE_ONLY(1)) dutA (
    .pclk(pclk), .prst(prst), .apb(ifA), .proto_err(protoErrA), .viol_count(violA));
  apb_mem_completer #(.PROTOCOL(3), .ADDR_W(16), .DATA_W(32), .DEPTH(256),
                      .WAIT_STATES(0), .SECURE_ONLY(1)) dutB (
    .pclk(pclk), .prst(prst), .apb(ifB), .proto_err(protoErrB), .viol_count(violB));
  apb_mem_completer #(.PROTOCOL(4), .ADDR_W(16), .DATA_W(32), .DEPTH(256),
                      .WAIT_STATES(3), .SECURE_ONLY(0)) dutC (
    .pclk(pclk), .prst(prst), .apb(ifC), .proto_err(protoErrC), .viol_count(violC));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One complete transfer; glitchCycle flips paddr bit 3 during that access cycle.
  task automatic applyStimulus(input logic isWrite, input logic [15:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, input logic expErr,
                               input logic [31:0] expData, input int glitchCycle = -1);
    expect_t e;
    bit done = 1'b0;
    e.isWrite = isWrite;
    e.data    = expData;
    e.err     = expErr;
    e.waits   = (tgt == 2) ? 3 : 0;
    expQ.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = isWrite; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    tick();
    penable = 1'b1;
    for (int n = 0; n < 40; n++) begin
      paddr = (n == glitchCycle) ? (addr ^ 16'h0008) : addr;
      @(negedge pclk);
      if (curPready) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    tick();
    psel = 1'b0; penable = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL pready timeout: addr 0x%04h got no pready, expected pready within 40 cycles", addr);
      expQ.delete(expQ.size() - 1);
    end
  endtask

  // Monitor: pops one expectation per observed completion.
  int waitCount = 0;
  always @(negedge pclk) begin : monitor
    expect_t e;
    if (prst || !psel || !penable) begin
      waitCount = 0;
    end else if (!curPready) begin
      checkOutput("pslverr while waiting", {31'd0, curPslverr}, 32'd0);
      waitCount++;
    end else begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected completion: got pready=1, expected no transfer");
      end else begin
        e = expQ.pop_front();
        checkOutput("wait states", 32'(waitCount), 32'(e.waits));
        checkOutput("pslverr", {31'd0, curPslverr}, {31'd0, e.err});
        if (!e.isWrite) checkOutput("prdata", curPrdata, e.data);
      end
      waitCount = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge pclk);
    #1 prst = 1'b0;

    $display("[TB] reset state");
    checkOutput("A pready reset", {31'd0, ifA.pready}, 32'd0);
    checkOutput("A pslverr reset", {31'd0, ifA.pslverr}, 32'd0);
    checkOutput("A prdata reset", ifA.prdata, 32'd0);
    checkOutput("A proto_err reset", {31'd0, protoErrA}, 32'd0);
    checkOutput("C viol_count reset", {24'd0, violC}, 32'd0);

    $display("[TB] APB4, no wait states");
    tgt = 0;
    applyStimulus(1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(0, 16'h0010, 32'h0, 4'h0, 3'b000, 0, 32'hDEADBEEF);
    tick();
    checkOutput("A prdata hold", curPrdata, 32'hDEADBEEF);
    applyStimulus(1, 16'h0020, 32'h11223344, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(1, 16'h0020, 32'hAABBCCDD, 4'h5, 3'b000, 0, 32'h0);
    applyStimulus(0, 16'h0020, 32'h0, 4'h0, 3'b000, 0, 32'h11BB33DD);
    applyStimulus(1, 16'h03FC, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(0, 16'h03FC, 32'h0, 4'h0, 3'b000, 0, 32'hA5A5A5A5);
    applyStimulus(0, 16'h0400, 32'h0, 4'h0, 3'b000, 1, 32'h0);
    applyStimulus(1, 16'h0000, 32'h55667788, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(1, 16'h0002, 32'hFFFFFFFF, 4'hF, 3'b000, 1, 32'h0);
    applyStimulus(0, 16'h0000, 32'h0, 4'h0, 3'b000, 0, 32'h55667788);
    applyStimulus(1, 16'h0030, 32'hCAFEF00D, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(1, 16'h0030, 32'h12345678, 4'hF, 3'b010, 1, 32'h0);
    applyStimulus(0, 16'h0030, 32'h0, 4'h0, 3'b010, 1, 32'h0);
    applyStimulus(0, 16'h0030, 32'h0, 4'h0, 3'b000, 0, 32'hCAFEF00D);
    applyStimulus(1, 16'h0010, 32'h00000000, 4'h0, 3'b000, 0, 32'h0);
    checkOutput("A proto_err clean", {31'd0, protoErrA}, 32'd0);
    applyStimulus(0, 16'h0010, 32'h0, 4'hF, 3'b000, 0, 32'hDEADBEEF);
    checkOutput("A proto_err strobed read", {31'd0, protoErrA}, 32'd1);
    checkOutput("A viol_count strobed read", {24'd0, violA}, 32'd1);

    $display("[TB] APB3 lanes and protection ignored");
    tgt = 1;
    applyStimulus(1, 16'h0020, 32'h11223344, 4'hF, 3'b000, 0, 32'h0);
    applyStimulus(1, 16'h0020, 32'hAABBCCDD, 4'h5, 3'b010, 0, 32'h0);
    applyStimulus(0, 16'h0020, 32'h0, 4'hF, 3'b000, 0, 32'hAABBCCDD);
    checkOutput("B viol_count", {24'd0, violB}, 32'd0);

    $display("[TB] three wait states");
    tgt = 2;
    applyStimulus(1, 16'h0040, 32'h0BADC0DE, 4'hF, 3'b000, 0, 32'h0);
    startCycle = cycleCount;
    applyStimulus(0, 16'h0040, 32'h0, 4'h0, 3'b000, 0, 32'h0BADC0DE);
    checkOutput("C single transfer cycles", 32'(cycleCount - startCycle), 32'd5);
    startCycle = cycleCount;
    applyStimulus(0, 16'h0040, 32'h0, 4'h0, 3'b000, 0, 32'h0BADC0DE);
    applyStimulus(1, 16'h0044, 32'h01020304, 4'hF, 3'b000, 0, 32'h0);
    checkOutput("C back-to-back cycles", 32'(cycleCount - startCycle), 32'd10);

    $display("[TB] protocol monitor");
    penable = 1'b1;
    tick();
    penable = 1'b0;
    checkOutput("C viol penable in idle", {24'd0, violC}, 32'd1);
    psel = 1'b1; pwrite = 1'b1; paddr = 16'h0040; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    checkOutput("C viol abort", {24'd0, violC}, 32'd2);
    applyStimulus(0, 16'h0044, 32'h0, 4'h0, 3'b000, 0, 32'h01020304, 1);
    checkOutput("C proto_err", {31'd0, protoErrC}, 32'd1);
    checkOutput("C viol addr change", {24'd0, violC}, 32'd3);
    applyStimulus(0, 16'h0040, 32'h0, 4'h0, 3'b000, 0, 32'h0BADC0DE);

    $display("[TB] reset mid-transfer");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040;
    pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b000;
    tick();
    penable = 1'b1;
    tick();
    prst = 1'b1;
    tick();
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    checkOutput("C pready after reset", {31'd0, ifC.pready}, 32'd0);
    checkOutput("C pslverr after reset", {31'd0, ifC.pslverr}, 32'd0);
    checkOutput("C prdata after reset", ifC.prdata, 32'd0);
    checkOutput("C proto_err after reset", {31'd0, protoErrC}, 32'd0);
    checkOutput("C viol_count after reset", {24'd0, violC}, 32'd0);
    applyStimulus(0, 16'h0040, 32'h0, 4'h0, 3'b000, 0, 32'h0BADC0DE);
    tgt = 0;
    applyStimulus(0, 16'h0010, 32'h0, 4'h0, 3'b000, 0, 32'hDEADBEEF);

    tick();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
